// File: rtl/seq_tx_hex_uart.sv
// UART 8N1 transmitter that prints one accepted data word as uppercase ASCII hex,
// most significant nibble first, optionally followed by CR LF.
module seq_tx_hex_uart #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 868,
    parameter int SEND_CRLF  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_busy,
    output logic                  o_uart_tx
);
    localparam int NCHAR = DATA_WIDTH / 4;
    localparam int NTOT  = NCHAR + 2 * SEND_CRLF;
    localparam int CW    = $clog2(NTOT + 1);
    localparam int BW    = $clog2(CLK_DIV);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [CW-1:0]         char_q, char_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [7:0]            shift_q, shift_d;
    logic                  busy_q, busy_d;
    logic                  tx_q, tx_d;

    logic [DATA_WIDTH-1:0] src_word;
    logic [CW-1:0]         sel_idx;
    logic [7:0]            sel_code;
    logic [3:0]            nib [NCHAR];
    logic                  baud_end;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // The next character is formatted ahead of time: from the live input on the
    // accept edge, otherwise from the held word for the character after char_q.
    assign src_word = (state_q == S_IDLE) ? i_tx_data : word_q;
    assign sel_idx  = (state_q == S_IDLE) ? '0 : char_q + CW'(1);
    assign baud_end = (baud_q == BW'(CLK_DIV - 1));

    generate
        for (genvar gi = 0; gi < NCHAR; gi++) begin : g_nib
            assign nib[gi] = src_word[DATA_WIDTH-1-4*gi -: 4];
        end
    endgenerate

    always_comb begin
        sel_code = 8'h0A;
        if (SEND_CRLF != 0 && sel_idx == CW'(NCHAR)) sel_code = 8'h0D;
        for (int i = 0; i < NCHAR; i++) begin
            if (sel_idx == CW'(i)) sel_code = hex_char(nib[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        char_d  = char_q;
        word_d  = word_q;
        shift_d = shift_q;
        busy_d  = busy_q;
        tx_d    = tx_q;
        case (state_q)
            S_IDLE: begin
                if (i_tx_valid) begin
                    word_d  = i_tx_data;
                    shift_d = sel_code;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    char_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (char_q == CW'(NTOT - 1)) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        char_d  = char_q + CW'(1);
                        shift_d = sel_code;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            char_q  <= '0;
            word_q  <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            word_q  <= word_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            tx_q    <= tx_d;
        end
    end

    assign o_tx_busy = busy_q;
    assign o_uart_tx = tx_q;
endmodule
